// File: rtl/clock_phaser_pkg.sv
// Shared definitions for the clock phaser and the quadrant clock multiplexer.
package clock_phaser_pkg;

  localparam int unsigned PHASE_FINE_BITS = 6;
  localparam int unsigned PHASE_QUAD_BITS = 2;

  // Quadrant selects as seen by the quadrant clock multiplexer ({hcycle, qcycle}).
  localparam logic [PHASE_QUAD_BITS-1:0] Q000 = 2'd0;
  localparam logic [PHASE_QUAD_BITS-1:0] Q090 = 2'd1;
  localparam logic [PHASE_QUAD_BITS-1:0] Q180 = 2'd2;
  localparam logic [PHASE_QUAD_BITS-1:0] Q270 = 2'd3;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_IDLE,
    ST_CHECK,
    ST_STEP,
    ST_WAIT_DONE,
    ST_APPLY,
    ST_SETTLE
  } cp_state_e;

  // Counter width able to hold the larger of the two timed intervals.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/clock_phaser_ps_step_timer.sv
// Loadable down-counter shared by the psdone timeout and the settle interval.
module ps_step_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load takes priority; otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/clock_phaser.sv
// DCM fine phase walker and quadrant select controller.
module clock_phaser
  import clock_phaser_pkg::*;
#(
  parameter int unsigned FINE_BITS     = PHASE_FINE_BITS,
  parameter int unsigned PS_TIMEOUT    = 255,
  parameter int unsigned SETTLE_CYCLES = 15
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 phase_wr,
  input  logic [FINE_BITS+1:0] phase_val,
  input  logic                 dcm_locked,
  input  logic                 psdone,
  output logic                 psen,
  output logic                 psincdec,
  output logic                 hcycle,
  output logic                 qcycle,
  output logic                 busy,
  output logic [FINE_BITS+1:0] current_phase,
  output logic                 timeout_err
);

  localparam int unsigned TIMER_W = timer_width(PS_TIMEOUT, SETTLE_CYCLES);

  cp_state_e              state_q, state_d;
  logic [FINE_BITS-1:0]   fine_q, fine_d;
  logic [FINE_BITS+1:0]   target_q, target_d;
  logic                   psen_q, psen_d;
  logic                   psincdec_q, psincdec_d;
  logic                   hcycle_q, hcycle_d;
  logic                   qcycle_q, qcycle_d;
  logic                   busy_q, busy_d;
  logic                   terr_q, terr_d;
  logic [FINE_BITS-1:0]   tgt_fine;
  logic                   timer_load;
  logic [TIMER_W-1:0]     timer_val;
  logic                   timer_expired;

  ps_step_timer #(.W(TIMER_W)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  // A strobe arriving in the same cycle as CHECK is honoured immediately.
  assign tgt_fine = phase_wr ? phase_val[FINE_BITS-1:0] : target_q[FINE_BITS-1:0];

  // Next-state and registered-output logic; lock loss overrides every state.
  always_comb begin
    state_d    = state_q;
    fine_d     = fine_q;
    target_d   = target_q;
    psen_d     = 1'b0;
    psincdec_d = psincdec_q;
    hcycle_d   = hcycle_q;
    qcycle_d   = qcycle_q;
    busy_d     = busy_q;
    terr_d     = terr_q;
    timer_load = 1'b0;
    timer_val  = '0;

    if (phase_wr) begin
      target_d = phase_val;
      terr_d   = 1'b0;
    end

    if (!dcm_locked && (state_q != ST_WAIT_LOCK)) begin
      // Relock restores the DCM to zero offset, so forget the walked position.
      state_d = ST_WAIT_LOCK;
      fine_d  = '0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          busy_d = 1'b1;
          if (dcm_locked) state_d = ST_CHECK;
        end
        ST_IDLE: begin
          if (phase_wr) begin
            busy_d  = 1'b1;
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (fine_q == tgt_fine) begin
            state_d = ST_APPLY;
          end else begin
            state_d    = ST_STEP;
            psen_d     = 1'b1;
            psincdec_d = (tgt_fine > fine_q);
          end
        end
        ST_STEP: begin
          state_d    = ST_WAIT_DONE;
          timer_load = 1'b1;
          timer_val  = TIMER_W'(PS_TIMEOUT);
        end
        ST_WAIT_DONE: begin
          if (psdone) begin
            fine_d  = psincdec_q ? (fine_q + 1'b1) : (fine_q - 1'b1);
            state_d = ST_CHECK;
          end else if (timer_expired) begin
            if (phase_wr) begin
              state_d = ST_CHECK;
            end else begin
              terr_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
        ST_APPLY: begin
          // A new target here must be re-walked before any quadrant is applied.
          if (phase_wr) begin
            state_d = ST_CHECK;
          end else begin
            {hcycle_d, qcycle_d} = target_q[FINE_BITS +: PHASE_QUAD_BITS];
            state_d    = ST_SETTLE;
            timer_load = 1'b1;
            timer_val  = TIMER_W'(SETTLE_CYCLES);
          end
        end
        ST_SETTLE: begin
          if (phase_wr) begin
            state_d = ST_CHECK;
          end else if (timer_expired) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_WAIT_LOCK;
          busy_d  = 1'b1;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q              <= ST_WAIT_LOCK;
      fine_q               <= '0;
      target_q             <= '0;
      psen_q               <= 1'b0;
      psincdec_q           <= 1'b0;
      {hcycle_q, qcycle_q} <= Q000;
      busy_q               <= 1'b1;
      terr_q               <= 1'b0;
    end else begin
      state_q    <= state_d;
      fine_q     <= fine_d;
      target_q   <= target_d;
      psen_q     <= psen_d;
      psincdec_q <= psincdec_d;
      hcycle_q   <= hcycle_d;
      qcycle_q   <= qcycle_d;
      busy_q     <= busy_d;
      terr_q     <= terr_d;
    end
  end

  assign psen          = psen_q;
  assign psincdec      = psincdec_q;
  assign hcycle        = hcycle_q;
  assign qcycle        = qcycle_q;
  assign busy          = busy_q;
  assign timeout_err   = terr_q;
  assign current_phase = {hcycle_q, qcycle_q, fine_q};

endmodule

// File: tb/tb_clock_phaser.sv
// Randomized self-checking bench for clock_phaser with a DCM psdone responder.
`timescale 1ns/1ps
module tb_clock_phaser;

  localparam int SETTLE  = 15;
  localparam int TIMEOUT = 255;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       phase_wr;
  logic [7:0] phase_val;
  logic       dcm_locked;
  logic       psdone = 1'b0;
  logic       psen, psincdec, hcycle, qcycle, busy, timeout_err;
  logic [7:0] current_phase;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Responder / monitor state.
  int  resp_lat = 2;
  bit  resp_en  = 1'b1;
  int  pend     = 0;
  int  inc_cnt  = 0;
  int  dec_cnt  = 0;
  int  psen_unlocked = 0;
  int  psen_long = 0;
  bit  prev_psen = 1'b0;
  bit  dir_log[$];
  logic locked_at_edge = 1'b1;

  logic [7:0] model_phase = 8'h00;

  clock_phaser #(.FINE_BITS(6), .PS_TIMEOUT(TIMEOUT), .SETTLE_CYCLES(SETTLE)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .phase_wr      (phase_wr),
    .phase_val     (phase_val),
    .dcm_locked    (dcm_locked),
    .psdone        (psdone),
    .psen          (psen),
    .psincdec      (psincdec),
    .hcycle        (hcycle),
    .qcycle        (qcycle),
    .busy          (busy),
    .current_phase (current_phase),
    .timeout_err   (timeout_err)
  );

  always #12 clock = ~clock;

  // Lock status as the DUT saw it at each edge.
  always @(posedge clock) locked_at_edge <= dcm_locked;

  // DCM model: answers each psen with psdone after resp_lat cycles, logs every pulse.
  always @(posedge clock) begin
    #1;
    psdone = 1'b0;
    if (!reset_n) begin
      pend = 0;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) psdone = 1'b1;
    end
    if (psen) begin
      if (!locked_at_edge) psen_unlocked++;
      if (prev_psen) psen_long++;
      if (psincdec) inc_cnt++; else dec_cnt++;
      dir_log.push_back(psincdec);
      if (resp_en) pend = resp_lat;
    end
    prev_psen = psen;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic pw(input logic [7:0] v);
    phase_val = v;
    phase_wr  = 1'b1;
    tick();
    phase_wr  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_incs(input int base, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (inc_cnt - base >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Write a phase from idle and check the walk against the step count implied by the fine delta.
  task automatic do_phase(input logic [7:0] v);
    int bi, bd, qk, bk;
    logic [5:0] of, nf;
    logic [1:0] oq, nq;
    bi = inc_cnt; bd = dec_cnt;
    of = model_phase[5:0]; oq = model_phase[7:6];
    nf = v[5:0];           nq = v[7:6];
    qk = -1; bk = -1;
    pw(v);
    check_eq("busy_rise", busy, 1);
    check_eq("terr_after_wr", timeout_err, 0);
    for (int k = 2; k <= 4000; k++) begin
      tick();
      if (qk < 0 && {hcycle, qcycle} != oq) qk = k;
      if (!busy) begin
        bk = k;
        break;
      end
    end
    check_eq("idle_reached", bk > 0, 1);
    check_eq("phase", current_phase, v);
    check_eq("hcycle", hcycle, nq[1]);
    check_eq("qcycle", qcycle, nq[0]);
    check_eq("inc_steps", inc_cnt - bi, (nf > of) ? (nf - of) : 0);
    check_eq("dec_steps", dec_cnt - bd, (of > nf) ? (of - nf) : 0);
    if (nq != oq) begin
      check_eq("settle_len", bk - qk, SETTLE + 1);
      if (nf == of) check_eq("apply_lat", qk, 3);
    end
    model_phase = v;
  endtask

  initial begin
    #(60000 * 24);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int bi, bd, bl, up, sw, k;
    logic [7:0] cp;

    reset_n = 1'b0; phase_wr = 1'b0; phase_val = '0; dcm_locked = 1'b1;
    repeat (3) tick();
    check_eq("rst_busy", busy, 1);
    check_eq("rst_psen", psen, 0);
    check_eq("rst_psincdec", psincdec, 0);
    check_eq("rst_phase", current_phase, 0);
    check_eq("rst_terr", timeout_err, 0);
    reset_n = 1'b1;
    wait_idle(100, ok);
    check_eq("boot_idle", ok, 1);
    check_eq("boot_phase", current_phase, 0);
    check_eq("boot_no_psen", inc_cnt + dec_cnt, 0);

    // Directed walks, then randomized targets and responder latencies.
    do_phase(8'hC0);
    do_phase(8'h05);
    do_phase(8'hC2);
    repeat (8) begin
      resp_lat = $urandom_range(1, 4);
      do_phase(8'($urandom_range(0, 255)));
    end
    resp_lat = 2;

    // Lock loss mid-walk toward 0x10.
    do_phase(8'h00);
    bi = inc_cnt;
    pw(8'h10);
    wait_incs(bi, 5, 200, ok);
    check_eq("lock_walk_started", ok, 1);
    dcm_locked = 1'b0;
    tick();
    cp = current_phase;
    check_eq("lock_fine_zero", cp[5:0], 0);
    check_eq("lock_quad_hold", cp[7:6], 0);
    check_eq("lock_busy", busy, 1);
    check_eq("lock_psen", psen, 0);
    bl = inc_cnt + dec_cnt;
    repeat (20) tick();
    check_eq("unlocked_no_psen", inc_cnt + dec_cnt, bl);
    check_eq("unlocked_busy", busy, 1);
    dcm_locked = 1'b1;
    bi = inc_cnt; bd = dec_cnt;
    wait_idle(1000, ok);
    check_eq("relock_idle", ok, 1);
    check_eq("relock_incs", inc_cnt - bi, 16);
    check_eq("relock_decs", dec_cnt - bd, 0);
    check_eq("relock_phase", current_phase, 8'h10);
    model_phase = 8'h10;

    // psdone withheld: timeout after the programmed wait.
    resp_en = 1'b0;
    bi = inc_cnt;
    pw(8'h11);
    k = -1;
    for (int j = 2; j <= 400; j++) begin
      tick();
      if (timeout_err) begin
        k = j;
        break;
      end
    end
    check_eq("timeout_window", (k >= 250) && (k <= 270), 1);
    check_eq("timeout_busy", busy, 0);
    check_eq("timeout_phase", current_phase, 8'h10);
    check_eq("timeout_one_step", inc_cnt - bi, 1);
    repeat (3) tick();
    check_eq("timeout_sticky", timeout_err, 1);
    resp_en = 1'b1;
    do_phase(8'h11);

    // Retarget mid-walk: in-flight step completes, then the walk reverses.
    do_phase(8'h00);
    bi = inc_cnt; bd = dec_cnt; bl = dir_log.size();
    pw(8'h20);
    wait_incs(bi, 6, 200, ok);
    check_eq("rev_walk_started", ok, 1);
    pw(8'h03);
    wait_idle(1000, ok);
    check_eq("rev_idle", ok, 1);
    up = inc_cnt - bi;
    sw = 0;
    for (int i = bl + 1; i < dir_log.size(); i++) begin
      if (dir_log[i] != dir_log[i-1]) sw++;
    end
    check_eq("rev_up_steps", up, 6);
    check_eq("rev_down_steps", dec_cnt - bd, up - 3);
    check_eq("rev_dir_changes", sw, 1);
    check_eq("rev_phase", current_phase, 8'h03);
    model_phase = 8'h03;

    // Asynchronous reset in the middle of a walk.
    do_phase(8'hC3);
    bi = inc_cnt;
    pw(8'h3F);
    wait_incs(bi, 4, 200, ok);
    check_eq("arst_walk_started", ok, 1);
    #3 reset_n = 1'b0;
    #1;
    check_eq("arst_psen", psen, 0);
    check_eq("arst_busy", busy, 1);
    check_eq("arst_phase", current_phase, 0);
    check_eq("arst_terr", timeout_err, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    bi = inc_cnt + dec_cnt;
    wait_idle(100, ok);
    check_eq("arst_idle", ok, 1);
    check_eq("arst_final_phase", current_phase, 0);
    check_eq("arst_no_psen", inc_cnt + dec_cnt, bi);

    check_eq("psen_while_unlocked", psen_unlocked, 0);
    check_eq("psen_single_cycle", psen_long, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
